// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - turns button presses into round-robin arbitrated single events
module button_event_arbiter #(
  parameter int NUM_BTN     = 4,
  parameter int ID_W        = 2,
  parameter int LOCKOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_level,
  input  logic               evt_ready,
  input  logic               clr_err,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  output logic               drop_err,
  output logic               busy
);

  logic [NUM_BTN-1:0] prev_q;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   lock_q [NUM_BTN];
  logic [CNT_W-1:0]   lock_d [NUM_BTN];
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [NUM_BTN-1:0] rise;
  logic               load_ok;
  logic               found;
  logic               grant;
  logic [ID_W-1:0]    grant_idx;
  logic               drop;

  assign rise    = btn_level & ~prev_q;
  assign load_ok = !valid_q || evt_ready;
  assign grant   = found && load_ok;

  // Round-robin pick: nearest pending button after the last grant, wrapping.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!found && pending_q[i] &&
            (last_q == ID_W'((i - k + NUM_BTN) % NUM_BTN))) begin
          found     = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

  // Next state: event channel load/hold, pending set/clear, lockout timers, drop detection.
  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    id_d      = id_q;
    last_d    = last_q;
    drop      = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      lock_d[i] = lock_q[i];
    end

    if (grant) begin
      valid_d = 1'b1;
      id_d    = grant_idx;
      last_d  = grant_idx;
    end else if (load_ok) begin
      valid_d = 1'b0;
    end

    for (int i = 0; i < NUM_BTN; i++) begin
      // A grant reload beats the per-cycle countdown.
      if (grant && (grant_idx == ID_W'(i))) begin
        pending_d[i] = 1'b0;
        lock_d[i]    = CNT_W'(LOCKOUT_CYC);
      end else if (lock_q[i] != '0) begin
        lock_d[i] = lock_q[i] - CNT_W'(1);
      end
      // Presses inside the lockout window are bounce and vanish quietly;
      // a press on a button that is already pending (incl. being granted now) is lost.
      if (rise[i] && (lock_q[i] == '0)) begin
        if (pending_q[i]) begin
          drop = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
        end
      end
    end

    if (drop) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; prev_q resets high so buttons held through reset need a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '1;
      pending_q <= '0;
      last_q    <= ID_W'(NUM_BTN - 1);
      id_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        lock_q[i] <= '0;
      end
    end else begin
      prev_q    <= btn_level;
      pending_q <= pending_d;
      last_q    <= last_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        lock_q[i] <= lock_d[i];
      end
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign drop_err  = err_q;
  assign busy      = (|pending_q) | valid_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;
  localparam int NB = 4;
  localparam int IW = 2;
  localparam int LK = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_level;
  logic          evt_ready;
  logic          clr_err;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          drop_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .NUM_BTN(NB), .ID_W(IW), .LOCKOUT_CYC(LK), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level), .evt_ready(evt_ready),
    .clr_err(clr_err), .evt_valid(evt_valid), .evt_id(evt_id),
    .drop_err(drop_err), .busy(busy)
  );

  // Reference model state
  bit m_pend [NB];
  bit n_pend [NB];
  bit m_prev [NB];
  int m_lock [NB];
  int m_last, m_id, m_g;
  bit m_valid, m_err, m_drop, m_load, m_busy;

  // Reference model: applies the press/lockout/arbitration rules once per clock.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_pend[i] = 1'b0; m_prev[i] = 1'b1; m_lock[i] = 0;
      end
      m_last = NB - 1; m_id = 0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_load = !m_valid || evt_ready;
      m_g = -1;
      if (m_load)
        for (int k = 1; k <= NB; k++)
          if (m_g < 0 && m_pend[(m_last + k) % NB]) m_g = (m_last + k) % NB;
      m_drop = 1'b0;
      for (int i = 0; i < NB; i++) begin
        n_pend[i] = (i == m_g) ? 1'b0 : m_pend[i];
        if (btn_level[i] && !m_prev[i] && m_lock[i] == 0) begin
          if (m_pend[i]) m_drop = 1'b1;
          else n_pend[i] = 1'b1;
        end
        m_lock[i] = (i == m_g) ? LK : ((m_lock[i] > 0) ? m_lock[i] - 1 : 0);
        m_prev[i] = btn_level[i];
      end
      for (int i = 0; i < NB; i++) m_pend[i] = n_pend[i];
      if (m_load) begin
        if (m_g >= 0) begin
          m_valid = 1'b1; m_id = m_g; m_last = m_g;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (m_drop) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      m_busy = m_valid;
      for (int i = 0; i < NB; i++) if (m_pend[i]) m_busy = 1'b1;
      chk("model_valid", int'(evt_valid), int'(m_valid));
      chk("model_id",    int'(evt_id),    m_id);
      chk("model_err",   int'(drop_err),  int'(m_err));
      chk("model_busy",  int'(busy),      int'(m_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btn_level = '0; evt_ready = 1'b1; clr_err = 1'b0;
    tick(2);
    rst = 1'b0; chk_en = 1'b1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id",    int'(evt_id),    0);
    chk("rst_err",   int'(drop_err),  0);
    chk("rst_busy",  int'(busy),      0);

    // single press, held
    tick(1);
    btn_level = 4'b0100; tick(1);
    chk("t1_pend_busy", int'(busy), 1);
    chk("t1_not_yet",   int'(evt_valid), 0);
    tick(1);
    chk("t1_valid", int'(evt_valid), 1);
    chk("t1_id",    int'(evt_id),    2);
    tick(1);
    chk("t1_one_cycle", int'(evt_valid), 0);
    tick(8);
    chk("t1_hold_quiet", int'(evt_valid), 0);
    btn_level = '0; tick(6);

    // simultaneous press right after reset
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    btn_level = 4'b1001; tick(1);
    tick(1);
    chk("t2_first_id", int'(evt_id), 0);
    chk("t2_first_v",  int'(evt_valid), 1);
    tick(1);
    chk("t2_second_id", int'(evt_id), 3);
    chk("t2_second_v",  int'(evt_valid), 1);
    tick(1);
    chk("t2_idle", int'(evt_valid), 0);
    btn_level = '0; tick(6);

    // backpressure
    evt_ready = 1'b0;
    btn_level = 4'b0010; tick(2);
    chk("t3_first", int'(evt_id), 1);
    btn_level = 4'b0110; tick(10);
    chk("t3_stall_id",   int'(evt_id),    1);
    chk("t3_stall_v",    int'(evt_valid), 1);
    chk("t3_stall_busy", int'(busy),      1);
    evt_ready = 1'b1; tick(1);
    chk("t3_next_id", int'(evt_id), 2);
    chk("t3_next_v",  int'(evt_valid), 1);
    tick(1);
    chk("t3_drain", int'(evt_valid), 0);
    btn_level = '0; tick(6);

    // lockout window
    btn_level = 4'b0010; tick(2);
    chk("t4_grant", int'(evt_id), 1);
    btn_level = '0; tick(1);
    btn_level = 4'b0010; tick(1);
    chk("t4_locked_busy", int'(busy),     0);
    chk("t4_locked_err",  int'(drop_err), 0);
    btn_level = '0; tick(3);
    btn_level = 4'b0010; tick(1);
    chk("t4_refire_pend", int'(busy), 1);
    tick(1);
    chk("t4_refire_v",  int'(evt_valid), 1);
    chk("t4_refire_id", int'(evt_id),    1);
    tick(1); btn_level = '0; tick(6);

    // drop while pending, then clear
    evt_ready = 1'b0;
    btn_level = 4'b0001; tick(2);
    chk("t5_hold_id", int'(evt_id), 0);
    btn_level = 4'b1001; tick(1);
    btn_level = 4'b0001; tick(1);
    btn_level = 4'b1001; tick(1);
    chk("t5_err", int'(drop_err), 1);
    evt_ready = 1'b1; tick(1);
    chk("t5_id3", int'(evt_id), 3);
    tick(1);
    chk("t5_only_one", int'(evt_valid), 0);
    chk("t5_err_sticky", int'(drop_err), 1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("t5_cleared", int'(drop_err), 0);
    btn_level = '0; tick(6);

    // reset mid-operation
    evt_ready = 1'b0;
    btn_level = 4'b0001; tick(2);
    btn_level = 4'b0111; tick(1);
    btn_level = 4'b0101; tick(1);
    btn_level = 4'b0111; tick(1);
    chk("t6_pre_err",  int'(drop_err), 1);
    chk("t6_pre_busy", int'(busy),     1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t6_rst_valid", int'(evt_valid), 0);
    chk("t6_rst_busy",  int'(busy),      0);
    chk("t6_rst_err",   int'(drop_err),  0);
    evt_ready = 1'b1; tick(5);
    chk("t6_held_quiet", int'(busy), 0);
    btn_level = '0; tick(2);
    btn_level = 4'b0101; tick(2);
    chk("t6_first_id", int'(evt_id), 0);
    tick(1);
    chk("t6_second_id", int'(evt_id), 2);
    tick(1);
    chk("t6_idle", int'(evt_valid), 0);
    btn_level = '0; tick(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
